// File: rtl/dmem_access_unit_pkg.sv
// Shared constants, state encoding and lane helpers for the data-memory access stage.
package dmem_pkg;

   // Load access codes on DMCtrl when DMWR=0
   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   // Store access codes on DMCtrl when DMWR=1
   localparam logic [2:0] ST_SW  = 3'b000;
   localparam logic [2:0] ST_SH  = 3'b001;
   localparam logic [2:0] ST_SB  = 3'b010;

   // Byte-lane enables
   localparam logic [3:0] BE_ALL     = 4'b1111;
   localparam logic [3:0] BE_BYTE    = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_t;

   // Access code must exist and the address must be naturally aligned for its size.
   function automatic logic access_legal(input logic we, input logic [2:0] ctrl,
                                         input logic [1:0] lo);
      logic ok;
      ok = 1'b0;
      if (we) begin
         case (ctrl)
            ST_SB:   ok = 1'b1;
            ST_SH:   ok = ~lo[0];
            ST_SW:   ok = (lo == 2'b00);
            default: ok = 1'b0;
         endcase
      end else begin
         case (ctrl)
            LD_LB, LD_LBU: ok = 1'b1;
            LD_LH, LD_LHU: ok = ~lo[0];
            LD_LW:         ok = (lo == 2'b00);
            default:       ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   // Loads always read the full word; stores enable only the addressed lanes.
   function automatic logic [3:0] lane_be(input logic we, input logic [2:0] ctrl,
                                          input logic [1:0] lo);
      logic [3:0] be;
      be = BE_ALL;
      if (we) begin
         case (ctrl)
            ST_SB:   be = BE_BYTE << lo;
            ST_SH:   be = lo[1] ? BE_HALF_HI : BE_HALF_LO;
            default: be = BE_ALL;
         endcase
      end
      return be;
   endfunction

   // Sub-word store data is replicated so every lane carries it.
   function automatic logic [31:0] lane_wdata(input logic we, input logic [2:0] ctrl,
                                              input logic [31:0] wd);
      logic [31:0] d;
      d = '0;
      if (we) begin
         case (ctrl)
            ST_SB:   d = {4{wd[7:0]}};
            ST_SH:   d = {2{wd[15:0]}};
            default: d = wd;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Word-wide data-memory bus with req/ack handshake.
interface dmem_access_unit_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/dmem_access_unit_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
   import dmem_pkg::*;
(
   input  logic [2:0]  ctrl,
   input  logic [1:0]  lo,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Lane select then extension by access code
   always_comb begin
      sel_byte = word[7:0];
      case (lo)
         2'd0:    sel_byte = word[7:0];
         2'd1:    sel_byte = word[15:8];
         2'd2:    sel_byte = word[23:16];
         default: sel_byte = word[31:24];
      endcase
      sel_half = lo[1] ? word[31:16] : word[15:0];
      result   = '0;
      case (ctrl)
         LD_LB:   result = {{24{sel_byte[7]}}, sel_byte};
         LD_LBU:  result = {24'h0, sel_byte};
         LD_LH:   result = {{16{sel_half[15]}}, sel_half};
         LD_LHU:  result = {16'h0, sel_half};
         LD_LW:   result = word;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access stage: one req/ack transaction per load/store, stalling the core meanwhile.
module dmem_access_unit
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   input  logic               DMWR,
   input  logic [2:0]         DMCtrl,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic               stall,
   output logic               done,
   output logic               err,
   output logic [31:0]        rdata,
   dmem_access_unit_if.master mem
);

   localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t            state;
   logic [CntW-1:0]   cnt;
   logic              lat_we;
   logic [2:0]        lat_ctrl;
   logic [1:0]        lat_lo;
   logic              req_q;
   logic              we_q;
   logic [3:0]        be_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              done_q;
   logic              err_q;
   logic [31:0]       rdata_q;
   logic [31:0]       load_val;
   logic              legal;
   logic              unused_addr;

   assign legal = access_legal(DMWR, DMCtrl, addr[1:0]);

   // Byte-address bits above the memory's word space wrap around.
   assign unused_addr = ^addr[31:ADDR_W+2];

   load_extend u_load_extend (
      .ctrl   (lat_ctrl),
      .lo     (lat_lo),
      .word   (mem.mem_rdata),
      .result (load_val)
   );

   // Transaction FSM; every output it drives is registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         lat_we   <= 1'b0;
         lat_ctrl <= '0;
         lat_lo   <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
               cnt     <= '0;
               if (req_valid) begin
                  lat_we   <= DMWR;
                  lat_ctrl <= DMCtrl;
                  lat_lo   <= addr[1:0];
                  if (legal) begin
                     state   <= ISSUE;
                     req_q   <= 1'b1;
                     we_q    <= DMWR;
                     be_q    <= lane_be(DMWR, DMCtrl, addr[1:0]);
                     addr_q  <= addr[ADDR_W+1:2];
                     wdata_q <= lane_wdata(DMWR, DMCtrl, wdata);
                  end else begin
                     // Illegal accesses never touch memory
                     state  <= ERR;
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (mem.mem_ack) begin
                  state   <= RESP;
                  done_q  <= 1'b1;
                  rdata_q <= lat_we ? 32'h0 : load_val;
               end else if (cnt == CntW'(TIMEOUT - 2)) begin
                  // This cycle is the last of TIMEOUT-1 request cycles
                  state  <= ERR;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
               end
               cnt <= cnt + 1'b1;
               if (mem.mem_ack || cnt == CntW'(TIMEOUT - 2)) begin
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  be_q    <= '0;
                  addr_q  <= '0;
                  wdata_q <= '0;
               end
            end
            default: begin
               // RESP and ERR both present done for exactly one cycle
               state   <= IDLE;
               cnt     <= '0;
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
            end
         endcase
      end
   end

   // Stall is combinational so it already holds the core in the accept cycle
   always_comb begin
      stall = req_valid & ~rst & (state != RESP) & (state != ERR);
   end

   assign done          = done_q;
   assign err           = err_q;
   assign rdata         = rdata_q;
   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_be    = be_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit with a simple delayed-ack memory responder.
module tb_dmem_access_unit;
   import dmem_pkg::*;

   localparam int unsigned AW = 10;
   localparam int unsigned TO = 16;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        DMWR;
   logic [2:0]  DMCtrl;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic        done;
   logic        err;
   logic [31:0] rdata;

   dmem_access_unit_if #(.ADDR_W(AW)) mbus ();

   dmem_access_unit #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .DMWR      (DMWR),
      .DMCtrl    (DMCtrl),
      .addr      (addr),
      .wdata     (wdata),
      .stall     (stall),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .mem       (mbus)
   );

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];

   // Responder controls and observations
   logic        ack_en = 1'b1;
   int          ack_delay = 0;
   logic        stray = 1'b0;
   logic [31:0] mem_word = 32'h0;
   int          req_cnt = 0;
   logic        seen = 1'b0;
   logic        unstable = 1'b0;
   logic        cap_we;
   logic [3:0]  cap_be;
   logic [AW-1:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [AW+36:0] prev_bus;
   int          wait_cnt = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // Memory model: samples the bus mid-cycle and answers after ack_delay request cycles
   initial begin
      mbus.mem_ack   = 1'b0;
      mbus.mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (mbus.mem_req) begin
            if (seen && prev_bus !== {mbus.mem_we, mbus.mem_be, mbus.mem_addr, mbus.mem_wdata})
               unstable = 1'b1;
            prev_bus  = {mbus.mem_we, mbus.mem_be, mbus.mem_addr, mbus.mem_wdata};
            seen      = 1'b1;
            req_cnt++;
            cap_we    = mbus.mem_we;
            cap_be    = mbus.mem_be;
            cap_addr  = mbus.mem_addr;
            cap_wdata = mbus.mem_wdata;
            if (ack_en && wait_cnt >= ack_delay) begin
               mbus.mem_ack   = 1'b1;
               mbus.mem_rdata = mem_word;
            end else begin
               mbus.mem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            wait_cnt       = 0;
            mbus.mem_ack   = stray;
            mbus.mem_rdata = stray ? 32'h5555_AAAA : 32'h0;
         end
      end
   end

   task automatic to_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      DMWR      = 1'b0;
      DMCtrl    = 3'b000;
      addr      = 32'h0;
      wdata     = 32'h0;
   endtask

   task automatic drive(input logic we, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd);
      exp_t e;
      req_valid = 1'b1;
      DMWR      = we;
      DMCtrl    = c;
      addr      = a;
      wdata     = wd;
      e.err     = e_err;
      e.rdata   = e_rd;
      sb.push_back(e);
      req_cnt   = 0;
      seen      = 1'b0;
      unstable  = 1'b0;
   endtask

   // Cycle 0 is the first negedge after drive(); returns -1 if done never comes
   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      @(negedge clk);
      while (done !== 1'b1 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      if (done !== 1'b1) cyc = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      req_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({stall, done, err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctl: got %b want 000", {stall, done, err});
      end
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata: got %h want 0", rdata);
      end
      checks++;
      if ({mbus.mem_req, mbus.mem_we, mbus.mem_be} !== 6'h0) begin
         errors++;
         $display("FAIL reset_bus: got %b want 0", {mbus.mem_req, mbus.mem_we, mbus.mem_be});
      end
      checks++;
      if (mbus.mem_addr !== '0 || mbus.mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_addr: got %h/%h want 0/0", mbus.mem_addr, mbus.mem_wdata);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
   endtask

   task automatic test_lw_basic();
      exp_t e;
      mem_word = 32'hDEAD_BEEF;
      drive(1'b0, LD_LW, 32'h0000_0008, 32'h0, 1'b0, 32'hDEAD_BEEF);
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || mbus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL lw_c0: got stall=%b req=%b want 1/0", stall, mbus.mem_req);
      end
      @(negedge clk);
      checks++;
      if (mbus.mem_req !== 1'b1 || stall !== 1'b1) begin
         errors++;
         $display("FAIL lw_c1_req: got req=%b stall=%b want 1/1", mbus.mem_req, stall);
      end
      checks++;
      if (mbus.mem_addr !== 10'd2 || {mbus.mem_we, mbus.mem_be} !== 5'b0_1111) begin
         errors++;
         $display("FAIL lw_c1_bus: got addr=%0d we/be=%b want 2/01111", mbus.mem_addr,
                  {mbus.mem_we, mbus.mem_be});
      end
      @(negedge clk);
      if (sb.size() != 0) e = sb.pop_front();
      else e = 'x;
      checks++;
      if (done !== 1'b1 || err !== e.err || rdata !== e.rdata) begin
         errors++;
         $display("FAIL lw_c2_done: got done=%b err=%b rdata=%h want 1/%b/%h", done, err, rdata,
                  e.err, e.rdata);
      end
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL lw_c2_stall: got %b want 0", stall);
      end
      to_cycle();
      idle();
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || mbus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL lw_c3_idle: got done=%b req=%b want 0/0", done, mbus.mem_req);
      end
      to_cycle();
   endtask

   task automatic test_sub_loads();
      logic [2:0]  tc[6] = '{LD_LB, LD_LBU, LD_LHU, LD_LH, LD_LB, LD_LH};
      logic [31:0] ta[6] = '{32'h0000_0003, 32'hFFFF_FFFB, 32'h0000_0002,
                             32'h8000_0402, 32'h0000_0000, 32'h0000_1000};
      logic [31:0] te[6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF,
                             32'hFFFF_80FF, 32'h0000_007F, 32'hFFFF_FF7F};
      mem_word = 32'h80FF_FF7F;
      for (int i = 0; i < 6; i++) begin
         exp_t        e;
         int          cyc;
         logic [31:0] wa;
         wa = ta[i] >> 2;
         drive(1'b0, tc[i], ta[i], 32'h0, 1'b0, te[i]);
         wait_done(10, cyc);
         if (sb.size() != 0) e = sb.pop_front();
         else e = 'x;
         checks++;
         if (cyc != 2) begin
            errors++;
            $display("FAIL load%0d_lat: got %0d want 2", i, cyc);
         end
         checks++;
         if (err !== e.err || rdata !== e.rdata) begin
            errors++;
            $display("FAIL load%0d_data: got err=%b rdata=%h want %b/%h", i, err, rdata, e.err,
                     e.rdata);
         end
         checks++;
         if (cap_addr !== wa[AW-1:0] || cap_we !== 1'b0 || cap_be !== 4'b1111) begin
            errors++;
            $display("FAIL load%0d_bus: got addr=%h we=%b be=%b want %h/0/1111", i, cap_addr,
                     cap_we, cap_be, wa[AW-1:0]);
         end
         to_cycle();
         idle();
      end
      to_cycle();
   endtask

   task automatic test_stores();
      logic [2:0]  tc[4] = '{ST_SB, ST_SH, ST_SW, ST_SB};
      logic [31:0] ta[4] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 32'h0000_0007};
      logic [31:0] tw[4] = '{32'h1234_56AB, 32'h1234_56AB, 32'hCAFE_F00D, 32'h0000_00C3};
      logic [3:0]  tb[4] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000};
      logic [31:0] td[4] = '{32'hABAB_ABAB, 32'h56AB_56AB, 32'hCAFE_F00D, 32'hC3C3_C3C3};
      mem_word = 32'h7777_7777;
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         int   cyc;
         drive(1'b1, tc[i], ta[i], tw[i], 1'b0, 32'h0);
         wait_done(10, cyc);
         if (sb.size() != 0) e = sb.pop_front();
         else e = 'x;
         checks++;
         if (cyc != 2 || err !== e.err || rdata !== e.rdata) begin
            errors++;
            $display("FAIL store%0d_done: got cyc=%0d err=%b rdata=%h want 2/%b/%h", i, cyc,
                     err, rdata, e.err, e.rdata);
         end
         checks++;
         if (cap_we !== 1'b1 || cap_be !== tb[i] || cap_wdata !== td[i]) begin
            errors++;
            $display("FAIL store%0d_lane: got we=%b be=%b wd=%h want 1/%b/%h", i, cap_we,
                     cap_be, cap_wdata, tb[i], td[i]);
         end
         to_cycle();
         idle();
      end
      to_cycle();
   endtask

   task automatic test_illegal();
      logic        tw[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0]  tc[7] = '{LD_LW, LD_LH, ST_SH, ST_SW, 3'b011, 3'b100, 3'b110};
      logic [31:0] ta[7] = '{32'h2, 32'h3, 32'h1, 32'h6, 32'h0, 32'h0, 32'h0};
      mem_word = 32'h1111_2222;
      for (int i = 0; i < 7; i++) begin
         exp_t e;
         int   cyc;
         drive(tw[i], tc[i], ta[i], 32'hFFFF_FFFF, 1'b1, 32'h0);
         wait_done(10, cyc);
         if (sb.size() != 0) e = sb.pop_front();
         else e = 'x;
         checks++;
         if (cyc != 1 || err !== e.err || rdata !== e.rdata) begin
            errors++;
            $display("FAIL illegal%0d_done: got cyc=%0d err=%b rdata=%h want 1/%b/%h", i, cyc,
                     err, rdata, e.err, e.rdata);
         end
         checks++;
         if (req_cnt != 0) begin
            errors++;
            $display("FAIL illegal%0d_noreq: got %0d req cycles want 0", i, req_cnt);
         end
         to_cycle();
         idle();
      end
      to_cycle();
   endtask

   task automatic test_timeout();
      exp_t e;
      int   cyc;
      ack_en = 1'b0;
      drive(1'b1, ST_SW, 32'h0000_0010, 32'hCAFE_F00D, 1'b1, 32'h0);
      wait_done(40, cyc);
      if (sb.size() != 0) e = sb.pop_front();
      else e = 'x;
      checks++;
      if (cyc != int'(TO) || err !== e.err || rdata !== e.rdata) begin
         errors++;
         $display("FAIL timeout_done: got cyc=%0d err=%b rdata=%h want %0d/%b/%h", cyc, err,
                  rdata, TO, e.err, e.rdata);
      end
      checks++;
      if (req_cnt != int'(TO) - 1 || mbus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL timeout_req: got %0d cycles req=%b want %0d/0", req_cnt, mbus.mem_req,
                  TO - 1);
      end
      checks++;
      if (unstable !== 1'b0 || cap_be !== 4'b1111 || cap_wdata !== 32'hCAFE_F00D
          || cap_addr !== 10'd4) begin
         errors++;
         $display("FAIL timeout_stable: got unst=%b be=%b wd=%h addr=%h want 0/1111/cafef00d/4",
                  unstable, cap_be, cap_wdata, cap_addr);
      end
      ack_en = 1'b1;
      to_cycle();
      idle();
      to_cycle();
   endtask

   task automatic test_stray_ack();
      stray = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || mbus.mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL stray%0d: got done=%b req=%b stall=%b want 0/0/0", i, done,
                     mbus.mem_req, stall);
         end
      end
      stray = 1'b0;
      to_cycle();
      to_cycle();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   cyc;
      mem_word = 32'h0BAD_F00D;
      drive(1'b0, LD_LW, 32'h0000_0020, 32'h0, 1'b0, 32'h0BAD_F00D);
      wait_done(10, cyc);
      if (sb.size() != 0) e = sb.pop_front();
      else e = 'x;
      checks++;
      if (cyc != 2 || rdata !== e.rdata) begin
         errors++;
         $display("FAIL b2b_first: got cyc=%0d rdata=%h want 2/%h", cyc, rdata, e.rdata);
      end
      to_cycle();
      mem_word = 32'h1357_9BDF;
      drive(1'b0, LD_LW, 32'h0000_0024, 32'h0, 1'b0, 32'h1357_9BDF);
      wait_done(10, cyc);
      if (sb.size() != 0) e = sb.pop_front();
      else e = 'x;
      checks++;
      if (cyc != 2 || rdata !== e.rdata || cap_addr !== 10'd9) begin
         errors++;
         $display("FAIL b2b_second: got cyc=%0d rdata=%h addr=%h want 2/%h/9", cyc, rdata,
                  cap_addr, e.rdata);
      end
      to_cycle();
      idle();
      // req_valid dropped mid-ISSUE must not cancel the access
      ack_delay = 3;
      mem_word  = 32'h2468_ACE0;
      drive(1'b0, LD_LHU, 32'h0000_002A, 32'h0, 1'b0, 32'h0000_2468);
      to_cycle();
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mbus.mem_req !== 1'b1) begin
         errors++;
         $display("FAIL drop_issue: got stall=%b req=%b want 0/1", stall, mbus.mem_req);
      end
      wait_done(10, cyc);
      if (sb.size() != 0) e = sb.pop_front();
      else e = 'x;
      checks++;
      if (cyc != 3 || err !== e.err || rdata !== e.rdata) begin
         errors++;
         $display("FAIL drop_done: got cyc=%0d err=%b rdata=%h want 3/%b/%h", cyc, err, rdata,
                  e.err, e.rdata);
      end
      ack_delay = 0;
      to_cycle();
      idle();
      to_cycle();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   cyc;
      ack_en = 1'b0;
      drive(1'b0, LD_LW, 32'h0000_0030, 32'h0, 1'b0, 32'h0);
      to_cycle();
      to_cycle();
      to_cycle();
      @(negedge clk);
      checks++;
      if (mbus.mem_req !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre: got req=%b want 1", mbus.mem_req);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (mbus.mem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async: got req=%b stall=%b done=%b want 0/0/0", mbus.mem_req,
                  stall, done);
      end
      // Abandoned access produces no result
      if (sb.size() != 0) e = sb.pop_back();
      to_cycle();
      rst = 1'b0;
      idle();
      ack_en   = 1'b1;
      mem_word = 32'h7E57_0001;
      to_cycle();
      drive(1'b0, LD_LW, 32'h0000_0030, 32'h0, 1'b0, 32'h7E57_0001);
      wait_done(10, cyc);
      if (sb.size() != 0) e = sb.pop_front();
      else e = 'x;
      checks++;
      if (cyc != 2 || err !== e.err || rdata !== e.rdata || cap_addr !== 10'h00C) begin
         errors++;
         $display("FAIL rstmid_after: got cyc=%0d err=%b rdata=%h addr=%h want 2/%b/%h/00c",
                  cyc, err, rdata, cap_addr, e.err, e.rdata);
      end
      to_cycle();
      idle();
      to_cycle();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_lw_basic();
      test_sub_loads();
      test_stores();
      test_illegal();
      test_timeout();
      test_stray_ack();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
